// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-wire serial link (transmitter FSM encoding, idle level).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_link_pkg;

  // Transmitter FSM encoding; 2'b11 is unused and decodes back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Level held on the line whenever no pattern bit is being sent.
  localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Control/data bundle between the stimulus controller and the serial transmitter.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored while the transmitter is busy.
// Ports: start/pattern/reps/abort flow controller -> transmitter,
//        w/w_valid/busy/done flow transmitter -> controller and line.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [REP_W-1:0] reps;
  logic             abort;
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, reps, abort,
    input  w, w_valid, busy, done
  );

  modport slave (
    input  start, pattern, reps, abort,
    output w, w_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx_piso_reg.sv
// Parallel-in serial-out shift register, MSB first, zero fill from the LSB end.
// Latency: loaded word's MSB appears on sout the cycle after load.
// Backpressure: none; priority is clear > load > shift.
// Ports: clk, reset (async high), clear/load/shift_en controls, din parallel word, sout serial bit.
module piso_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign sout = q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured word out MSB-first, repeated reps times (0 acts as 1).
// Latency: start at edge t -> first bit in cycle t+1, last bit t+W*R, done t+W*R+1, idle t+W*R+2.
// Backpressure: start is accepted only in IDLE; starts while busy are dropped, abort cancels.
// Ports: clk, reset (async high), bus (slave side of serial_pattern_tx_if).
module serial_pattern_tx
  import serial_link_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   REP_W    = 4,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_pattern_tx_if.slave   bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  state_t            state;
  state_t            next_state;
  logic [WIDTH-1:0]  shadow;
  logic [CW-1:0]     bit_cnt;
  logic [REP_W-1:0]  rep_cnt;

  logic              accept;
  logic              last_bit;
  logic              more_reps;
  logic              shifting;

  logic              piso_clear;
  logic              piso_load;
  logic              piso_shift;
  logic [WIDTH-1:0]  piso_din;
  logic              sout;

  // abort beats a simultaneous start in IDLE
  assign accept    = (state == ST_IDLE) && bus.start && !bus.abort;
  assign last_bit  = (bit_cnt == '0);
  assign more_reps = (rep_cnt > REP_W'(1));
  assign shifting  = (state == ST_SHIFT) && !bus.abort;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bus.abort)                  next_state = ST_IDLE;
        else if (last_bit && !more_reps) next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------- output decode (Moore, from registers only) ----------------
  always_comb begin
    bus.w       = IDLE_BIT;
    bus.w_valid = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state)
      ST_SHIFT: begin
        bus.w       = sout;
        bus.w_valid = 1'b1;
        bus.busy    = 1'b1;
      end
      ST_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------- counters and pattern shadow ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
    end else if (accept) begin
      shadow  <= bus.pattern;
      bit_cnt <= LAST_IDX;
      rep_cnt <= (bus.reps == '0) ? REP_W'(1) : bus.reps;
    end else if ((state == ST_SHIFT || state == ST_DONE) && bus.abort) begin
      bit_cnt <= '0;
      rep_cnt <= '0;
    end else if (shifting) begin
      if (last_bit && more_reps) begin
        // back-to-back repetition: no gap cycle between words
        bit_cnt <= LAST_IDX;
        rep_cnt <= rep_cnt - REP_W'(1);
      end else if (!last_bit) begin
        bit_cnt <= bit_cnt - CW'(1);
      end
    end
  end

  // ---------------- shift register control ----------------
  always_comb begin
    piso_clear = (state == ST_SHIFT || state == ST_DONE) && bus.abort;
    piso_load  = accept || (shifting && last_bit && more_reps);
    piso_shift = shifting;
    piso_din   = accept ? bus.pattern : shadow;
  end

  piso_reg #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk      (clk),
    .reset    (reset),
    .clear    (piso_clear),
    .load     (piso_load),
    .shift_en (piso_shift),
    .din      (piso_din),
    .sout     (sout)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
module tb_serial_pattern_tx;

  localparam int   WIDTH    = 8;
  localparam int   REP_W    = 4;
  localparam logic IDLE_BIT = 1'b0;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] rp;
    int         exp_len;  // expected number of valid bits
    int         mode;     // 0 plain, 1 start while busy, 2 abort at bit 5, 3 detector loopback
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];
  logic [3:0] det_hist;
  logic det_out;
  vec_t vecs[7];

  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus ();

  serial_pattern_tx #(
    .WIDTH    (WIDTH),
    .REP_W    (REP_W),
    .IDLE_BIT (IDLE_BIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Sequence detector on the line: Moore output for the last four samples == 1101
  always @(posedge clk or posedge reset) begin
    if (reset) det_hist <= 4'b0000;
    else       det_hist <= {det_hist[2:0], bus.w};
  end
  assign det_out = (det_hist == 4'b1101);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every valid bit on the line pops one expected bit
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.w_valid) begin
        if (exp_q.size() == 0) chk("unexpected_bit", bus.w_valid, 0);
        else                   chk("w_bit", bus.w, exp_q.pop_front());
      end else begin
        chk("w_idle_level", bus.w, IDLE_BIT);
      end
    end
  end

  task automatic send(input vec_t v);
    int n;
    int last_k;
    int busy_k;
    n      = v.exp_len;
    last_k = (v.mode == 2) ? 5 : n;
    busy_k = (v.mode == 2) ? 5 : n + 1;
    @(posedge clk); #1;
    bus.pattern = v.pat;
    bus.reps    = v.rp;
    bus.start   = 1'b1;
    for (int r = 0; r < n / 8; r++)
      for (int i = 7; i >= 0; i--)
        if (r * 8 + (7 - i) < last_k) exp_q.push_back(v.pat[i]);
    @(posedge clk); #1;   // this edge is t
    bus.start = 1'b0;
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      if (v.mode == 1 && k == 4) begin
        bus.start   = 1'b1;
        bus.pattern = 8'hFF;
        bus.reps    = 4'd2;
      end
      if (v.mode == 1 && k == 5) bus.start = 1'b0;
      if (v.mode == 2 && k == 5) bus.abort = 1'b1;
      if (v.mode == 2 && k == 6) bus.abort = 1'b0;
      chk({v.name, "_valid"}, bus.w_valid, (k <= last_k));
      chk({v.name, "_busy"},  bus.busy,    (k <= busy_k));
      chk({v.name, "_done"},  bus.done,    (v.mode != 2 && k == n + 1));
      if (v.mode == 3) chk({v.name, "_detect"}, det_out, (k == 7));
    end
    chk({v.name, "_queue_left"}, exp_q.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hB2, 4'd1,   8, 0, "basic"};
    vecs[1] = '{8'hA5, 4'd3,  24, 0, "reps3"};
    vecs[2] = '{8'hA5, 4'd0,   8, 0, "reps0"};
    vecs[3] = '{8'h01, 4'd15, 120, 0, "reps15"};
    vecs[4] = '{8'hB2, 4'd1,   8, 1, "busy_start"};
    vecs[5] = '{8'hC3, 4'd1,   8, 2, "abort"};
    vecs[6] = '{8'h34, 4'd1,   8, 3, "loopback"};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    bus.reps    = '0;
    #1;
    chk("rst_w",       bus.w,       IDLE_BIT);
    chk("rst_w_valid", bus.w_valid, 0);
    chk("rst_busy",    bus.busy,    0);
    chk("rst_done",    bus.done,    0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) send(vecs[i]);

    // abort together with start in IDLE: nothing happens
    @(posedge clk); #1;
    bus.pattern = 8'hFF; bus.reps = 4'd1;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("abort_start_busy",  bus.busy,    0);
      chk("abort_start_valid", bus.w_valid, 0);
    end

    // start held high: two transfers separated by exactly two idle cycles
    @(posedge clk); #1;
    bus.pattern = 8'h96; bus.reps = 4'd1; bus.start = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 7; i >= 0; i--) exp_q.push_back(bus.pattern[i]);
    @(posedge clk); #1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 11) bus.start = 1'b0;
      chk("held_valid", bus.w_valid, ((k >= 1 && k <= 8) || (k >= 11 && k <= 18)));
      chk("held_done",  bus.done,    (k == 9 || k == 19));
      if (k == 9 || k == 10) chk("held_gap_w", bus.w, IDLE_BIT);
    end
    chk("held_queue_left", exp_q.size(), 0);
    repeat (4) @(posedge clk);

    // asynchronous reset during bit 3
    @(posedge clk); #1;
    bus.pattern = 8'hB2; bus.reps = 4'd1; bus.start = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(bus.pattern[i]);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", bus.w_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_w",       bus.w,       IDLE_BIT);
    chk("async_rst_w_valid", bus.w_valid, 0);
    chk("async_rst_busy",    bus.busy,    0);
    chk("async_rst_done",    bus.done,    0);
    exp_q.delete();
    #4;
    chk("held_rst_busy", bus.busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_done", bus.done, 0);
    send(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
